// File: rtl/da_coef_rom_reader_if.sv
// Handshake and ROM-port bundle for the bit-serial DA coefficient evaluator.
// The evaluator attaches through the slave modport; its environment uses master.
interface da_coef_rom_reader_if #(
    parameter int unsigned B     = 16,
    parameter int unsigned ACC_W = 34
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [B-1:0]     x0;
    logic signed [B-1:0]     x1;
    logic signed [B-1:0]     x2;
    logic signed [B-1:0]     x3;
    logic                    rom_cs;
    logic [2:0]              rom_addr;
    logic [16:0]             rom_data;
    logic signed [ACC_W-1:0] y;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_valid, x0, x1, x2, x3, rom_data, out_ready,
        input  in_ready, rom_cs, rom_addr, y, out_valid
    );

    modport slave (
        input  in_valid, x0, x1, x2, x3, rom_data, out_ready,
        output in_ready, rom_cs, rom_addr, y, out_valid
    );
endinterface

// File: rtl/da_coef_rom_reader.sv
// Bit-serial distributed-arithmetic evaluator: walks four samples LSB first, one lookup
// per bit in the 8-entry offset-binary coefficient ROM, and shift-accumulates one z-term.
module da_coef_rom_reader #(
    parameter int unsigned             B      = 16,
    parameter int unsigned             ACC_W  = 34,
    parameter logic signed [ACC_W-1:0] OFFSET = '0
) (
    input logic                 clk,
    input logic                 rst_n,
    da_coef_rom_reader_if.slave bus
);
    localparam int unsigned IdxW = (B > 1) ? $clog2(B) : 1;

    typedef enum logic [1:0] {
        StResetWait,
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e                  state_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic signed [ACC_W-1:0] y_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [B-1:0]            s0_q;
    logic [B-1:0]            s1_q;
    logic [B-1:0]            s2_q;
    logic [B-1:0]            s3_q;
    logic [IdxW-1:0]         j_q;

    logic                    b0;
    logic [2:0]              lut_idx;
    logic                    last_bit;
    logic signed [ACC_W-1:0] rom_ext;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] term_sh;
    logic signed [ACC_W-1:0] acc_next;
    logic                    unused_rom_msb;

    assign b0       = s0_q[0];
    assign lut_idx  = {s1_q[0], s2_q[0], s3_q[0]};
    assign last_bit = (j_q == IdxW'(B - 1));

    // The ROM only stores the b0=0 half; the b0=1 half is the negated complement entry.
    assign bus.rom_cs   = (state_q == StRun);
    assign bus.rom_addr = (state_q == StRun) ? (b0 ? ~lut_idx : lut_idx) : 3'd0;

    assign unused_rom_msb = bus.rom_data[16];
    assign rom_ext  = {{(ACC_W - 16){bus.rom_data[15]}}, bus.rom_data[15:0]};
    assign term     = b0 ? -rom_ext : rom_ext;
    assign term_sh  = term <<< j_q;
    // The top bit of a two's-complement sample carries negative weight.
    assign acc_next = last_bit ? (acc_q - term_sh) : (acc_q + term_sh);

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StResetWait;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            acc_q       <= '0;
            s0_q        <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            j_q         <= '0;
        end else begin
            case (state_q)
                // One idle edge after reset lets the ROM finish its reset-sync blanking.
                StResetWait: begin
                    state_q    <= StIdle;
                    in_ready_q <= 1'b1;
                end
                StIdle: begin
                    if (bus.in_valid) begin
                        s0_q       <= bus.x0;
                        s1_q       <= bus.x1;
                        s2_q       <= bus.x2;
                        s3_q       <= bus.x3;
                        acc_q      <= OFFSET;
                        j_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    acc_q <= acc_next;
                    s0_q  <= s0_q >> 1;
                    s1_q  <= s1_q >> 1;
                    s2_q  <= s2_q >> 1;
                    s3_q  <= s3_q >> 1;
                    j_q   <= j_q + IdxW'(1);
                    if (last_bit) begin
                        y_q         <= acc_next;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StResetWait;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_da_coef_rom_reader.sv
// Self-checking bench for da_coef_rom_reader: fixed test-plan patterns plus random
// sample sets against a bit-serial weighted-sum reference model.
module tb_da_coef_rom_reader;
    localparam int unsigned B     = 16;
    localparam int unsigned ACC_W = 34;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    da_coef_rom_reader_if #(.B(B), .ACC_W(ACC_W)) bus ();
    da_coef_rom_reader_if #(.B(B), .ACC_W(ACC_W)) bus2 ();

    da_coef_rom_reader #(.B(B), .ACC_W(ACC_W), .OFFSET(34'sd0)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    da_coef_rom_reader #(.B(B), .ACC_W(ACC_W), .OFFSET(34'sd100)) dut_off (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus2)
    );

    function automatic int rom_int(input int a);
        case (a)
            0:       return -4927;
            1:       return 8696;
            2:       return -1730;
            3:       return 11892;
            4:       return -20996;
            5:       return -7373;
            6:       return -17800;
            default: return -4177;
        endcase
    endfunction

    always_comb bus.rom_data  = {1'b0, 16'(rom_int(int'(bus.rom_addr)))};
    always_comb bus2.rom_data = {1'b0, 16'(rom_int(int'(bus2.rom_addr)))};

    // y = OFFSET + sum_j w_j * T(column j), w_j = 2^j except w_{B-1} = -2^(B-1),
    // T = ROM value for b0=0, negated complement-address value for b0=1.
    function automatic longint ref_y(input logic [15:0] a0, input logic [15:0] a1,
                                     input logic [15:0] a2, input logic [15:0] a3,
                                     input longint off);
        longint acc;
        acc = off;
        for (int j = 0; j < int'(B); j++) begin
            int     a;
            int     t;
            longint w;
            a = 4 * int'(a1[j]) + 2 * int'(a2[j]) + int'(a3[j]);
            t = a0[j] ? -rom_int(7 - a) : rom_int(a);
            w = longint'(1) << j;
            if (j == int'(B) - 1) w = -w;
            acc += longint'(t) * w;
        end
        return acc;
    endfunction

    function automatic logic [15:0] rand_sample();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7fff;
            2:       return 16'hffff;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic accept(input logic [15:0] a0, input logic [15:0] a1,
                          input logic [15:0] a2, input logic [15:0] a3, output bit ok);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (bus.in_ready === 1'b1);
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout in_ready=%b want 1", bus.in_ready);
            return;
        end
        bus.x0 = a0; bus.x1 = a1; bus.x2 = a2; bus.x3 = a3;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.rom_cs, bus.rom_addr} !== 6'b0 || bus.y !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got rdy=%b vld=%b cs=%b addr=%0d y=%0d want all 0",
                     bus.in_ready, bus.out_valid, bus.rom_cs, bus.rom_addr, bus.y);
        end
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release_ready got %b want 0", bus.in_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_first_edge got rdy=%b vld=%b want rdy=1 vld=0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    logic [15:0] fx0 [3] = '{16'h0000, 16'hffff, 16'h0000};
    logic [15:0] fx1 [3] = '{16'h0000, 16'h0000, 16'h0001};
    logic [2:0]  fad0[3] = '{3'd0, 3'd7, 3'd4};
    logic [2:0]  fadr[3] = '{3'd0, 3'd7, 3'd0};
    int          fy  [3] = '{4927, -4177, -11142};

    task automatic test_fixed_patterns();
        bit ok;
        for (int c = 0; c < 3; c++) begin
            accept(fx0[c], fx1[c], 16'h0, 16'h0, ok);
            if (!ok) return;
            for (int j = 0; j < int'(B); j++) begin
                logic [2:0] ea;
                ea = (j == 0) ? fad0[c] : fadr[c];
                n_cmp++;
                if (bus.rom_cs !== 1'b1 || bus.rom_addr !== ea || bus.out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL pat%0d_run_j%0d got cs=%b addr=%0d vld=%b want cs=1 addr=%0d vld=0",
                             c, j, bus.rom_cs, bus.rom_addr, bus.out_valid, ea);
                end
                @(posedge clk); #1;
            end
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.rom_cs !== 1'b0 ||
                $signed(bus.y) !== ACC_W'(fy[c])) begin
                n_bad++;
                $display("FAIL pat%0d_result got vld=%b rdy=%b cs=%b y=%0d want vld=1 rdy=0 cs=0 y=%0d",
                         c, bus.out_valid, bus.in_ready, bus.rom_cs, $signed(bus.y), fy[c]);
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            n_cmp++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL pat%0d_handoff got vld=%b rdy=%b want vld=0 rdy=1",
                         c, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_offset();
        int n = 0;
        logic signed [ACC_W-1:0] e;
        e = ACC_W'(ref_y(16'h0, 16'h1, 16'h0, 16'h0, 100));
        bus2.x0 = '0; bus2.x1 = 16'sd1; bus2.x2 = '0; bus2.x3 = '0;
        bus2.in_valid = 1'b1;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        while (bus2.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (bus2.out_valid !== 1'b1 || $signed(bus2.y) !== e || e !== -34'sd11042) begin
            n_bad++;
            $display("FAIL offset_result got vld=%b y=%0d want vld=1 y=-11042",
                     bus2.out_valid, $signed(bus2.y));
        end
        bus2.out_ready = 1'b1;
        @(posedge clk); #1;
        bus2.out_ready = 1'b0;
    endtask

    task automatic test_hold();
        bit ok;
        logic [15:0] a0, a1, a2, a3;
        logic signed [ACC_W-1:0] e;
        a0 = rand_sample(); a1 = rand_sample(); a2 = rand_sample(); a3 = rand_sample();
        e = ACC_W'(ref_y(a0, a1, a2, a3, 0));
        accept(a0, a1, a2, a3, ok);
        if (!ok) return;
        repeat (B) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || $signed(bus.y) !== e) begin
                n_bad++;
                $display("FAIL hold_c%0d got vld=%b rdy=%b y=%0d want vld=1 rdy=0 y=%0d",
                         k, bus.out_valid, bus.in_ready, $signed(bus.y), e);
            end
            bus.in_valid = (k == 2);
            bus.x0 = rand_sample(); bus.x1 = rand_sample();
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_release got rdy=%b vld=%b want rdy=1 vld=0",
                     bus.in_ready, bus.out_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.rom_cs !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_ignored_pulse got rdy=%b cs=%b want rdy=1 cs=0",
                     bus.in_ready, bus.rom_cs);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        accept(rand_sample(), rand_sample(), 16'h1234, 16'hff00, ok);
        if (!ok) return;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.rom_cs, bus.rom_addr} !== 6'b0 || bus.y !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs got rdy=%b vld=%b cs=%b addr=%0d y=%0d want all 0",
                     bus.in_ready, bus.out_valid, bus.rom_cs, bus.rom_addr, bus.y);
        end
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_wait got rdy=%b vld=%b want 0 0", bus.in_ready, bus.out_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_ready got %b want 1", bus.in_ready);
        end
        accept(16'h0, 16'h0, 16'h0, 16'h0, ok);
        if (!ok) return;
        repeat (B) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || $signed(bus.y) !== 34'sd4927) begin
            n_bad++;
            $display("FAIL midreset_next got vld=%b y=%0d want vld=1 y=4927",
                     bus.out_valid, $signed(bus.y));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        longint exp_q[$];
        int n_acc = 0;
        int n_out = 0;
        int cyc = 0;
        int last_acc = -1;
        bit took;
        bus.x0 = rand_sample(); bus.x1 = rand_sample();
        bus.x2 = rand_sample(); bus.x3 = rand_sample();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        while (n_out < 20 && cyc < 600) begin
            took = 1'b0;
            if (bus.in_ready === 1'b1 && bus.out_valid === 1'b1) begin
                n_cmp++; n_bad++;
                $display("FAIL b2b_both_high at cycle %0d", cyc);
            end
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                exp_q.push_back(ref_y(bus.x0, bus.x1, bus.x2, bus.x3, 0));
                if (last_acc >= 0) begin
                    n_cmp++;
                    if (cyc - last_acc != 18) begin
                        n_bad++;
                        $display("FAIL b2b_spacing%0d got %0d want 18", n_acc, cyc - last_acc);
                    end
                end
                last_acc = cyc;
                n_acc++;
                took = 1'b1;
            end
            if (bus.out_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_spurious y=%0d want no output", $signed(bus.y));
                end else begin
                    logic signed [ACC_W-1:0] e;
                    e = ACC_W'(exp_q.pop_front());
                    if ($signed(bus.y) !== e) begin
                        n_bad++;
                        $display("FAIL b2b_y%0d got %0d want %0d", n_out, $signed(bus.y), e);
                    end
                end
                n_out++;
            end
            @(posedge clk); #1;
            cyc++;
            if (took) begin
                bus.x0 = rand_sample(); bus.x1 = rand_sample();
                bus.x2 = rand_sample(); bus.x3 = rand_sample();
                if (n_acc == 20) bus.in_valid = 1'b0;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        n_cmp++;
        if (n_out != 20) begin
            n_bad++;
            $display("FAIL b2b_timeout got %0d results want 20", n_out);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.x0 = '0; bus.x1 = '0; bus.x2 = '0; bus.x3 = '0;
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
        bus2.x0 = '0; bus2.x1 = '0; bus2.x2 = '0; bus2.x3 = '0;
        test_reset();
        test_fixed_patterns();
        test_offset();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
